// File: rtl/projection_axi4_mem_slave_if.sv
// AXI4 full channel bundle (AW/W/B/AR/R) between the projection master and its burst-RAM slave.
interface projection_axi4_mem_slave_if #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 10
);
  logic [C_S_AXI_ID_WIDTH-1:0]       s_axi_awid;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr;
  logic [7:0]                        s_axi_awlen;
  logic                              s_axi_awvalid;
  logic                              s_axi_awready;
  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb;
  logic                              s_axi_wlast;
  logic                              s_axi_wvalid;
  logic                              s_axi_wready;
  logic [C_S_AXI_ID_WIDTH-1:0]       s_axi_bid;
  logic [1:0]                        s_axi_bresp;
  logic                              s_axi_bvalid;
  logic                              s_axi_bready;
  logic [C_S_AXI_ID_WIDTH-1:0]       s_axi_arid;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr;
  logic [7:0]                        s_axi_arlen;
  logic                              s_axi_arvalid;
  logic                              s_axi_arready;
  logic [C_S_AXI_ID_WIDTH-1:0]       s_axi_rid;
  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata;
  logic [1:0]                        s_axi_rresp;
  logic                              s_axi_rlast;
  logic                              s_axi_rvalid;
  logic                              s_axi_rready;

  modport master (
    output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    output s_axi_rready
  );

  modport slave (
    input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bid, s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    input  s_axi_rready
  );
endinterface

// File: rtl/projection_axi4_mem_slave.sv
// AXI4 INCR-burst RAM slave, one outstanding burst per direction; first read beat 1 cycle after AR.
// Reads hold beat data under !rready, writes stall only via W_RESP until bready; RAM is read-first.
module projection_axi4_mem_slave #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 10
) (
  input  logic                        clock,
  input  logic                        reset,
  projection_axi4_mem_slave_if.slave  s_axi
);
  localparam int LP_NB    = C_S_AXI_DATA_WIDTH / 8;
  localparam int LP_LSB   = $clog2(LP_NB);
  localparam int LP_WAW   = C_S_AXI_ADDR_WIDTH - LP_LSB;
  localparam int LP_DEPTH = 1 << LP_WAW;
  localparam int IDW      = C_S_AXI_ID_WIDTH;
  localparam int DW       = C_S_AXI_DATA_WIDTH;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  logic [DW-1:0] r_mem [LP_DEPTH];

  wstate_t           r_wstate, w_wstate_nxt;
  logic              r_awready;
  logic [IDW-1:0]    r_wid;
  logic [LP_WAW-1:0] r_waddr;
  logic [7:0]        r_awlen;
  logic [8:0]        r_wcnt;
  logic [1:0]        r_bresp;
  logic              w_wready, w_bvalid, w_aw_hs, w_w_hs, w_b_hs, w_wr_en;

  rstate_t           r_rstate, w_rstate_nxt;
  logic              r_arready;
  logic [IDW-1:0]    r_rid;
  logic [DW-1:0]     r_rdata;
  logic              r_rlast;
  logic [LP_WAW-1:0] r_raddr;
  logic [7:0]        r_arlen;
  logic [7:0]        r_rcnt;
  logic              w_rvalid, w_ar_hs, w_r_hs;
  logic [LP_WAW-1:0] w_ar_word;
  logic              w_unused;

  assign w_aw_hs   = s_axi.s_axi_awvalid & r_awready;
  assign w_w_hs    = s_axi.s_axi_wvalid & w_wready;
  assign w_b_hs    = w_bvalid & s_axi.s_axi_bready;
  // Beats beyond awlen are accepted but dropped; the counter parks at awlen+1.
  assign w_wr_en   = w_w_hs & (r_wcnt <= {1'b0, r_awlen}) & ~reset;
  assign w_ar_hs   = s_axi.s_axi_arvalid & r_arready;
  assign w_r_hs    = w_rvalid & s_axi.s_axi_rready;
  assign w_ar_word = s_axi.s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:LP_LSB];
  assign w_unused  = &{1'b0, s_axi.s_axi_awaddr[LP_LSB-1:0], s_axi.s_axi_araddr[LP_LSB-1:0]};

  always_ff @(posedge clock) begin
    if (reset) r_wstate <= W_IDLE;
    else       r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
      W_DATA:  if (w_w_hs && s_axi.s_axi_wlast) w_wstate_nxt = W_RESP;
      W_RESP:  if (w_b_hs) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_wready = (r_wstate == W_DATA);
    w_bvalid = (r_wstate == W_RESP);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_awready <= 1'b0;
      r_wid     <= '0;
      r_waddr   <= '0;
      r_awlen   <= '0;
      r_wcnt    <= '0;
      r_bresp   <= 2'b00;
    end else begin
      r_awready <= (w_wstate_nxt == W_IDLE);
      if (w_aw_hs) begin
        r_wid   <= s_axi.s_axi_awid;
        r_waddr <= s_axi.s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:LP_LSB];
        r_awlen <= s_axi.s_axi_awlen;
        r_wcnt  <= '0;
      end
      if (w_wr_en) begin
        r_waddr <= r_waddr + LP_WAW'(1);
        r_wcnt  <= r_wcnt + 9'd1;
      end
      if (w_w_hs && s_axi.s_axi_wlast)
        r_bresp <= (r_wcnt == {1'b0, r_awlen}) ? 2'b00 : 2'b10;
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr_en)
      for (int b = 0; b < LP_NB; b++)
        if (s_axi.s_axi_wstrb[b]) r_mem[r_waddr][8*b +: 8] <= s_axi.s_axi_wdata[8*b +: 8];
  end

  always_ff @(posedge clock) begin
    if (reset) r_rstate <= R_IDLE;
    else       r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (w_r_hs && r_rlast) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_rvalid = (r_rstate == R_DATA);
  end

  // The next beat is fetched on the same edge that retires the current one.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_arready <= 1'b0;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rlast   <= 1'b0;
      r_raddr   <= '0;
      r_arlen   <= '0;
      r_rcnt    <= '0;
    end else begin
      r_arready <= (w_rstate_nxt == R_IDLE);
      if (w_ar_hs) begin
        r_rid   <= s_axi.s_axi_arid;
        r_arlen <= s_axi.s_axi_arlen;
        r_rdata <= r_mem[w_ar_word];
        r_raddr <= w_ar_word + LP_WAW'(1);
        r_rcnt  <= 8'd1;
        r_rlast <= (s_axi.s_axi_arlen == 8'd0);
      end else if (w_r_hs && !r_rlast) begin
        r_rdata <= r_mem[r_raddr];
        r_raddr <= r_raddr + LP_WAW'(1);
        r_rlast <= (r_rcnt == r_arlen);
        r_rcnt  <= r_rcnt + 8'd1;
      end else if (w_r_hs) begin
        r_rlast <= 1'b0;
      end
    end
  end

  assign s_axi.s_axi_awready = r_awready;
  assign s_axi.s_axi_wready  = w_wready;
  assign s_axi.s_axi_bid     = r_wid;
  assign s_axi.s_axi_bresp   = r_bresp;
  assign s_axi.s_axi_bvalid  = w_bvalid;
  assign s_axi.s_axi_arready = r_arready;
  assign s_axi.s_axi_rid     = r_rid;
  assign s_axi.s_axi_rdata   = r_rdata;
  assign s_axi.s_axi_rresp   = 2'b00;
  assign s_axi.s_axi_rlast   = r_rlast;
  assign s_axi.s_axi_rvalid  = w_rvalid;
endmodule

// File: tb/tb_projection_axi4_mem_slave.sv
// Randomized AXI4 master driving projection_axi4_mem_slave against a word-array reference memory.
module tb_projection_axi4_mem_slave;
  localparam int IDW = 1, DW = 32, AW = 10, DEPTH = 256;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  projection_axi4_mem_slave_if #(.C_S_AXI_ID_WIDTH(IDW), .C_S_AXI_DATA_WIDTH(DW),
                                 .C_S_AXI_ADDR_WIDTH(AW)) axi ();
  projection_axi4_mem_slave #(.C_S_AXI_ID_WIDTH(IDW), .C_S_AXI_DATA_WIDTH(DW),
                              .C_S_AXI_ADDR_WIDTH(AW)) dut (.clock(clock), .reset(reset), .s_axi(axi));

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference memory: a plain word array, known only after a full-strobe write.
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];

  typedef struct { logic [31:0] data; bit known; bit last; logic id; } rexp_t;
  typedef struct { logic [1:0] resp; logic id; } bexp_t;
  rexp_t       exp_r[$];
  bexp_t       exp_b[$];
  logic [31:0] rx[$];
  logic [1:0]  last_bresp;
  logic [31:0] wd[$];
  logic [3:0]  ws[$];

  always @(negedge clock) begin
    if (!reset) begin
      if (axi.s_axi_bvalid) begin
        chk("awready_during_b", axi.s_axi_awready, 0);
        if (exp_b.size() == 0) chk("unexpected_bvalid", axi.s_axi_bvalid, 0);
        else begin
          chk("bresp", axi.s_axi_bresp, exp_b[0].resp);
          chk("bid", axi.s_axi_bid, exp_b[0].id);
          if (axi.s_axi_bready) begin
            last_bresp = axi.s_axi_bresp;
            void'(exp_b.pop_front());
          end
        end
      end
      if (axi.s_axi_rvalid) begin
        if (exp_r.size() == 0) chk("unexpected_rvalid", axi.s_axi_rvalid, 0);
        else begin
          if (exp_r[0].known) chk("rdata", axi.s_axi_rdata, exp_r[0].data);
          chk("rlast", axi.s_axi_rlast, exp_r[0].last);
          chk("rid", axi.s_axi_rid, exp_r[0].id);
          chk("rresp", axi.s_axi_rresp, 0);
          if (axi.s_axi_rready) begin
            rx.push_back(axi.s_axi_rdata);
            void'(exp_r.pop_front());
          end
        end
      end
    end
  end

  task automatic do_write(input logic [9:0] addr, input logic [7:0] len, input logic id, input int bstall);
    int         nb = wd.size();
    int         n;
    logic [7:0] word = addr[9:2];
    for (int i = 0; i < nb; i++) begin
      if (i <= int'(len)) begin
        for (int b = 0; b < 4; b++) if (ws[i][b]) m_mem[word][8*b +: 8] = wd[i][8*b +: 8];
        if (ws[i] == 4'hF) m_known[word] = 1'b1;
        word++;
      end
    end
    exp_b.push_back('{resp: (nb - 1 == int'(len)) ? 2'b00 : 2'b10, id: id});
    axi.s_axi_awid = id; axi.s_axi_awaddr = addr; axi.s_axi_awlen = len; axi.s_axi_awvalid = 1'b1;
    n = 0;
    while (!axi.s_axi_awready && n < 50) begin @(posedge clock); #1; n++; end
    chk("awready_wait", axi.s_axi_awready, 1);
    @(posedge clock); #1;
    axi.s_axi_awvalid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      while ($urandom_range(3) == 0) begin axi.s_axi_wvalid = 1'b0; @(posedge clock); #1; end
      axi.s_axi_wdata = wd[i]; axi.s_axi_wstrb = ws[i];
      axi.s_axi_wlast = (i == nb - 1); axi.s_axi_wvalid = 1'b1;
      n = 0;
      while (!axi.s_axi_wready && n < 50) begin @(posedge clock); #1; n++; end
      chk("wready_wait", axi.s_axi_wready, 1);
      @(posedge clock); #1;
    end
    axi.s_axi_wvalid = 1'b0; axi.s_axi_wlast = 1'b0;
    n = 0;
    while (!axi.s_axi_bvalid && n < 50) begin @(posedge clock); #1; n++; end
    chk("bvalid_wait", axi.s_axi_bvalid, 1);
    for (int k = 0; k < bstall; k++) begin
      @(posedge clock); #1;
      chk("bvalid_hold", axi.s_axi_bvalid, 1);
      chk("awready_hold", axi.s_axi_awready, 0);
    end
    axi.s_axi_bready = 1'b1;
    @(posedge clock); #1;
    axi.s_axi_bready = 1'b0;
    chk("b_consumed", exp_b.size(), 0);
    chk("awready_after_b", axi.s_axi_awready, 1);
  endtask

  task automatic push_read_exp(input logic [9:0] addr, input logic [7:0] len, input logic id);
    logic [7:0] word = addr[9:2];
    for (int i = 0; i <= int'(len); i++) begin
      exp_r.push_back('{data: m_mem[word], known: m_known[word], last: (i == int'(len)), id: id});
      word++;
    end
  endtask

  task automatic ar_handshake(input logic [9:0] addr, input logic [7:0] len, input logic id);
    int n = 0;
    axi.s_axi_arid = id; axi.s_axi_araddr = addr; axi.s_axi_arlen = len; axi.s_axi_arvalid = 1'b1;
    while (!axi.s_axi_arready && n < 50) begin @(posedge clock); #1; n++; end
    chk("arready_wait", axi.s_axi_arready, 1);
    @(posedge clock); #1;
    axi.s_axi_arvalid = 1'b0;
    chk("rvalid_latency", axi.s_axi_rvalid, 1);
  endtask

  task automatic do_read(input logic [9:0] addr, input logic [7:0] len, input logic id, input bit rand_rdy);
    int n = 0;
    rx.delete();
    push_read_exp(addr, len, id);
    ar_handshake(addr, len, id);
    while (exp_r.size() > 0 && n < 2000) begin
      axi.s_axi_rready = rand_rdy ? 1'($urandom_range(1)) : 1'b1;
      @(posedge clock); #1; n++;
    end
    axi.s_axi_rready = 1'b0;
    chk("read_drained", exp_r.size(), 0);
    chk("rvalid_after_last", axi.s_axi_rvalid, 0);
  endtask

  task automatic fill_rand(input logic [7:0] len);
    int nb = int'(len) + 1;
    if ($urandom_range(9) == 0) nb = $urandom_range(1, int'(len) + 3);
    wd.delete(); ws.delete();
    for (int i = 0; i < nb; i++) begin
      wd.push_back($urandom);
      ws.push_back(($urandom_range(4) < 3) ? 4'hF : 4'($urandom_range(15)));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1);
  end

  initial begin
    logic [7:0] len;
    reset = 1'b1;
    axi.s_axi_awid = '0; axi.s_axi_awaddr = '0; axi.s_axi_awlen = '0; axi.s_axi_awvalid = 1'b0;
    axi.s_axi_wdata = '0; axi.s_axi_wstrb = '0; axi.s_axi_wlast = 1'b0; axi.s_axi_wvalid = 1'b0;
    axi.s_axi_bready = 1'b0;
    axi.s_axi_arid = '0; axi.s_axi_araddr = '0; axi.s_axi_arlen = '0; axi.s_axi_arvalid = 1'b0;
    axi.s_axi_rready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_awready", axi.s_axi_awready, 0);
    chk("rst_wready", axi.s_axi_wready, 0);
    chk("rst_bvalid", axi.s_axi_bvalid, 0);
    chk("rst_bid", axi.s_axi_bid, 0);
    chk("rst_bresp", axi.s_axi_bresp, 0);
    chk("rst_arready", axi.s_axi_arready, 0);
    chk("rst_rvalid", axi.s_axi_rvalid, 0);
    chk("rst_rid", axi.s_axi_rid, 0);
    chk("rst_rdata", axi.s_axi_rdata, 0);
    chk("rst_rresp", axi.s_axi_rresp, 0);
    chk("rst_rlast", axi.s_axi_rlast, 0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("awready_after_rst", axi.s_axi_awready, 1);
    chk("arready_after_rst", axi.s_axi_arready, 1);

    wd.delete(); ws.delete();
    for (int i = 1; i <= 8; i++) begin wd.push_back(32'(i)); ws.push_back(4'hF); end
    do_write(10'h000, 8'd7, 1'b0, 0);
    chk("burst8_bresp", last_bresp, 2'b00);
    do_read(10'h000, 8'd7, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) chk("burst8_rdata", rx[i], 32'(i + 1));

    wd = '{32'hFFFF_FFFF}; ws = '{4'hF};
    do_write(10'h00C, 8'd0, 1'b0, 0);
    wd = '{32'h0000_0000}; ws = '{4'b0101};
    do_write(10'h00E, 8'd0, 1'b1, 5);
    do_read(10'h00C, 8'd0, 1'b0, 1'b1);
    chk("strobe_merge", rx[0], 32'hFF00_FF00);

    wd = '{32'hA, 32'hB, 32'hC, 32'hD}; ws = '{4'hF, 4'hF, 4'hF, 4'hF};
    do_write(10'h3F8, 8'd3, 1'b1, 2);
    do_read(10'h3F8, 8'd3, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) chk("wrap_rdata", rx[i], 32'hA + 32'(i));
    do_read(10'h000, 8'd1, 1'b0, 1'b0);
    chk("wrap_word0", rx[0], 32'hC);
    chk("wrap_word1", rx[1], 32'hD);

    wd = '{32'h11, 32'h22}; ws = '{4'hF, 4'hF};
    do_write(10'h100, 8'd3, 1'b1, 0);
    chk("early_wlast_bresp", last_bresp, 2'b10);
    wd = '{32'h33}; ws = '{4'hF};
    do_write(10'h140, 8'd0, 1'b0, 1);
    chk("recover_bresp", last_bresp, 2'b00);
    do_read(10'h100, 8'd1, 1'b1, 1'b0);
    chk("early_beat1", rx[0], 32'h11);
    chk("early_beat2", rx[1], 32'h22);

    // Reset while beat 3 of an 8-beat read is presented.
    push_read_exp(10'h000, 8'd7, 1'b0);
    ar_handshake(10'h000, 8'd7, 1'b0);
    axi.s_axi_rready = 1'b1;
    for (int n = 0; n < 50 && exp_r.size() > 6; n++) begin @(posedge clock); #1; end
    chk("pre_reset_beats", exp_r.size(), 6);
    reset = 1'b1; axi.s_axi_rready = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_r.delete();
    chk("rst_mid_rvalid", axi.s_axi_rvalid, 0);
    chk("rst_mid_arready_low", axi.s_axi_arready, 0);
    @(posedge clock); #1;
    chk("rst_mid_arready", axi.s_axi_arready, 1);
    do_read(10'h004, 8'd5, 1'b1, 1'b1);

    for (int it = 0; it < 40; it++) begin
      len = 8'($urandom_range(15));
      if ($urandom_range(1) == 0) begin
        fill_rand(len);
        do_write(10'($urandom_range(1023)), len, 1'($urandom_range(1)), $urandom_range(3));
      end else begin
        do_read(10'($urandom_range(1023)), len, 1'($urandom_range(1)), 1'b1);
      end
    end

    // Concurrent traffic on disjoint halves of the RAM.
    for (int it = 0; it < 10; it++) begin
      len = 8'($urandom_range(12));
      fill_rand(len);
      fork
        do_write(10'($urandom_range(10'h1C0)), len, 1'($urandom_range(1)), $urandom_range(3));
        do_read(10'h200 + 10'($urandom_range(10'h1C0)), 8'($urandom_range(12)), 1'($urandom_range(1)), 1'b1);
      join
    end

    repeat (3) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
